// File: rtl/fpu_exception_handler_pkg.sv
// Shared FPU exception definitions.
// Holds the operation codes, the exception codes, the default-result
// constants of the S.EEEE.MMM format (bias 7), the trap-mask bit indices,
// the handler FSM state type and small code helpers.
package fpu_exception_handler_pkg;

    // Operation codes (shared by datapath and handler)
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Exception codes
    localparam logic [2:0] EXC_NONE      = 3'd0;
    localparam logic [2:0] EXC_SNAN      = 3'd1;
    localparam logic [2:0] EXC_INVALID   = 3'd2;
    localparam logic [2:0] EXC_DIV_ZERO  = 3'd3;
    localparam logic [2:0] EXC_OVERFLOW  = 3'd4;
    localparam logic [2:0] EXC_UNDERFLOW = 3'd5;
    localparam logic [2:0] EXC_INEXACT   = 3'd6;
    localparam logic [2:0] EXC_RSVD      = 3'd7;

    // Default results
    localparam logic [7:0] NAN_Q    = 8'h7C;
    localparam logic [6:0] INF_MAG  = 7'h78;
    localparam logic [6:0] ZERO_MAG = 7'h00;

    // Trap-mask / sticky-flag bit indices (bit k belongs to code k+1)
    localparam int TRAP_BIT_SNAN      = 0;
    localparam int TRAP_BIT_INVALID   = 1;
    localparam int TRAP_BIT_DIV_ZERO  = 2;
    localparam int TRAP_BIT_OVERFLOW  = 3;
    localparam int TRAP_BIT_UNDERFLOW = 4;
    localparam int TRAP_BIT_INEXACT   = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] code;
    } log_entry_t;

    // Code actually acted on: no exception -> NONE, reserved code 7 -> INVALID.
    function automatic logic [2:0] norm_code(input logic exce, input logic [2:0] code);
        logic [2:0] c;
        c = code;
        if (!exce)
            c = EXC_NONE;
        else if (code == EXC_RSVD)
            c = EXC_INVALID;
        return c;
    endfunction

    // One-hot flag position of an (already normalised) code; NONE -> 0.
    function automatic logic [5:0] code_onehot(input logic [2:0] code);
        logic [5:0] oh;
        oh = '0;
        case (code)
            EXC_SNAN:      oh[TRAP_BIT_SNAN]      = 1'b1;
            EXC_INVALID:   oh[TRAP_BIT_INVALID]   = 1'b1;
            EXC_DIV_ZERO:  oh[TRAP_BIT_DIV_ZERO]  = 1'b1;
            EXC_OVERFLOW:  oh[TRAP_BIT_OVERFLOW]  = 1'b1;
            EXC_UNDERFLOW: oh[TRAP_BIT_UNDERFLOW] = 1'b1;
            EXC_INEXACT:   oh[TRAP_BIT_INEXACT]   = 1'b1;
            default:       oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/fpu_exce_log_fifo.sv
// Event-log FIFO for the FPU exception handler.
// Synchronous FIFO of DEPTH entries (power of two, >= 2) with a sticky
// overflow flag. A write into a full FIFO is dropped and sets overflow,
// unless a read happens in the same cycle, in which case both succeed.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   wr_en/wr_data push request and data
//   rd_en         pop request (ignored while empty)
//   clr_ovf       clears overflow (a same-cycle drop still sets it)
//   empty         no entries
//   rd_data       head entry, 0 while empty
//   overflow      sticky: an entry was dropped
module fpu_exce_log_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             clr_ovf,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign drop    = wr_en && full && !do_pop;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            overflow <= (clr_ovf ? 1'b0 : overflow) | drop;
        end
    end

    // Storage needs no reset: rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fpu_exception_handler.sv
// FPU exception handler (consumer side of the exception interface).
// Accepts each result with its exception code, substitutes the format's
// default result, accumulates sticky flags, logs events into a FIFO and
// raises a trap request for exceptions whose trap is enabled. Trapping
// events produce no output beat and block input until trap_ack.
// Ports:
//   in_valid/in_ready, in_op, in_exce, in_exce_code, in_result : input beat
//   out_valid/out_ready, out_result, out_exce_code            : output beat
//   trap_mask, trap_req, trap_ack, trap_op, trap_code          : trap control
//   sticky_flags, sticky_clr                                   : status flags
//   log_rd_en, log_empty, log_rd_data, log_overflow            : event log
module fpu_exception_handler
    import fpu_exception_handler_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LOG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_exce,
    input  logic [2:0]        in_exce_code,
    input  logic [DATA_W-1:0] in_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [2:0]        out_exce_code,
    input  logic [5:0]        trap_mask,
    output logic [5:0]        sticky_flags,
    input  logic              sticky_clr,
    output logic              trap_req,
    input  logic              trap_ack,
    output logic [1:0]        trap_op,
    output logic [2:0]        trap_code,
    input  logic              log_rd_en,
    output logic              log_empty,
    output logic [4:0]        log_rd_data,
    output logic              log_overflow
);

    // Default-result substitution. The format is S.EEEE.MMM, so the
    // constants are sized for DATA_W = 8; bit DATA_W-1 carries the sign.
    function automatic logic [DATA_W-1:0] subst(input logic [2:0] code,
                                                input logic [DATA_W-1:0] res);
        logic [DATA_W-1:0] r;
        case (code)
            EXC_SNAN, EXC_INVALID:     r = NAN_Q;
            EXC_DIV_ZERO, EXC_OVERFLOW: r = {res[DATA_W-1], INF_MAG};
            EXC_UNDERFLOW:             r = {res[DATA_W-1], ZERO_MAG};
            default:                   r = res;
        endcase
        return r;
    endfunction

    state_e     state_q;
    state_e     state_d;
    logic [2:0] code_eff;
    logic [5:0] code_oh;
    logic       has_exc;
    logic       trap_hit;
    logic       xfer_in;
    logic       xfer_out;
    logic [5:0] sticky_set;
    log_entry_t log_wr;

    assign code_eff = norm_code(in_exce, in_exce_code);
    assign code_oh  = code_onehot(code_eff);
    assign has_exc  = (code_eff != EXC_NONE);
    assign trap_hit = has_exc && |(trap_mask & code_oh);

    // Output register frees up in the same cycle it is drained.
    assign in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;

    assign sticky_set = (xfer_in && has_exc) ? code_oh : '0;
    assign trap_req   = (state_q == ST_TRAP);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM: next state (trap_ack in IDLE has no effect)
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (xfer_in && trap_hit) state_d = ST_TRAP;
            ST_TRAP: if (trap_ack)            state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Trap context of the event that caused the trap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_op   <= '0;
            trap_code <= '0;
        end else if (xfer_in && trap_hit) begin
            trap_op   <= in_op;
            trap_code <= code_eff;
        end
    end

    // Output beat register: loaded on a non-trapping accept, held until drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_exce_code <= '0;
        end else if (xfer_in && !trap_hit) begin
            out_valid     <= 1'b1;
            out_result    <= subst(code_eff, in_result);
            out_exce_code <= code_eff;
        end else if (xfer_out) begin
            out_valid     <= 1'b0;
        end
    end

    // Sticky flags: a bit set in the clearing cycle survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_flags <= '0;
        else
            sticky_flags <= (sticky_clr ? 6'b0 : sticky_flags) | sticky_set;
    end

    assign log_wr.op   = in_op;
    assign log_wr.code = code_eff;

    fpu_exce_log_fifo #(
        .WIDTH (5),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (xfer_in && has_exc),
        .wr_data  (log_wr),
        .rd_en    (log_rd_en),
        .clr_ovf  (sticky_clr),
        .empty    (log_empty),
        .rd_data  (log_rd_data),
        .overflow (log_overflow)
    );

endmodule

// File: doc/fpu_exception_handler.md
Name: fpu_exception_handler

Overview:
- Consumer side of the FPU exception interface: takes each operation's result plus the exception flag/code produced by the exception detector.
- Substitutes the format-defined default result, accumulates sticky status flags and logs events in a small FIFO.
- Raises a trap request/acknowledge handshake for exceptions whose trap is enabled.
- Sits between the FPU datapath/exception detector and the result writeback/control interface.

Parameters:
- DATA_W, 8, operand/result width; format S.EEEE.MMM, bias 7
- LOG_DEPTH, 4, event-log FIFO entries (power of two)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  result+exception presented
- in_ready  out  1  handler can accept
- in_op  in  2  operation code (add/sub/mul/div, shared codes)
- in_exce  in  1  exception caught
- in_exce_code  in  3  exception code
- in_result  in  DATA_W  raw datapath result; bit 7 carries the correct result sign
- out_valid  out  1  final result valid
- out_ready  in  1  writeback accepts
- out_result  out  DATA_W  final, substituted result
- out_exce_code  out  3  code attached to out_result (0 if none)
- trap_mask  in  6  bit k=1 enables trap for code k+1
- sticky_flags  out  6  bit k set by code k+1
- sticky_clr  in  1  pulse; clears sticky_flags and log_overflow
- trap_req  out  1  trap pending
- trap_ack  in  1  trap acknowledged
- trap_op  out  2  op of trapping event
- trap_code  out  3  code of trapping event
- log_rd_en  in  1  pop event log
- log_empty  out  1  log empty
- log_rd_data  out  5  {op, code} at log head (valid when !log_empty)
- log_overflow  out  1  sticky: event dropped because log full

Behaviour:
- Codes: 0 NONE, 1 sNAN, 2 INVALID, 3 DIV_ZERO, 4 OVERFLOW, 5 UNDERFLOW, 6 INEXACT. Code 7 is handled as INVALID.
- Any code with in_exce=0 is handled as NONE.
- Reset: all outputs 0; log_empty=1; FSM in IDLE.
- FSM states: IDLE, TRAP.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Transfer in = in_valid && in_ready. Transfer out = out_valid && out_ready.
- Non-trapping accepted event: out_result/out_exce_code registered; out_valid=1 the next cycle (latency 1).
- out_valid holds and data stays stable until out_ready. Back-to-back accepts give full throughput.
- Substitution (S = in_result[7]):
  - sNAN/INVALID -> qNaN 8'h7C
  - DIV_ZERO/OVERFLOW -> {S, 7'h78} (signed infinity)
  - UNDERFLOW -> {S, 7'h00} (signed zero)
  - INEXACT/NONE -> in_result unchanged
- Trapping event: in_exce=1 and trap_mask[code-1]=1 (code 7 uses the INVALID bit).
  - No output beat is produced.
  - FSM goes to TRAP; trap_req=1 and trap_op/trap_code are latched, all from the next cycle.
  - in_ready=0 while in TRAP.
  - trap_ack while in TRAP -> IDLE; trap_req drops the next cycle.
  - trap_ack in IDLE is ignored.
- Sticky: every accepted event with in_exce=1 sets sticky_flags[code-1], trapping or not.
  - sticky_clr in the same cycle as a new set: cleared bits go to 0 except the newly set bit, which ends at 1.
- Event log (FIFO, LOG_DEPTH entries): every accepted event with in_exce=1 pushes {in_op, code}.
  - Pop on log_rd_en && !log_empty.
  - log_rd_en while empty is ignored.
  - Push while full with no pop: entry dropped, log_overflow set.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Pointers wrap modulo LOG_DEPTH, with an extra bit for full/empty.
- Reset mid-TRAP or mid-output-stall: everything returns to reset values and the pending beat is lost.

Decomposition:
- Shared defines file (existing FPU include) holds:
  - operation codes
  - the seven exception codes
  - constants NAN_Q=8'h7C, INF_MAG=7'h78, ZERO_MAG=7'h00
  - trap-mask bit indices
- One natural sub-module: fpu_exce_log_fifo (parameterised synchronous FIFO with full/empty/overflow).
- Substitution logic stays inline as a combinational function.

Test Plan:
- sNAN, mask=0: in_exce=1, code=1, in_result=8'h79, ADD -> next cycle out_result=8'h7C, out_exce_code=1; sticky_flags=6'b000001; log_rd_data={ADD,1}.
- DIV_ZERO, mask=0: code=3, in_result=8'hA0 (S=1) -> out_result=8'hF8. UNDERFLOW, in_result=8'h05 -> 8'h00. INEXACT, 8'h3A -> 8'h3A.
- Trap: trap_mask=6'b000100, DIV code=3 -> no out_valid; trap_req=1, trap_op=DIV, trap_code=3; in_ready=0 until trap_ack; trap_req=0 one cycle after ack.
- Backpressure: out_ready=0 for 3 cycles with two events offered -> first result held stable, second not accepted; release -> both delivered in order, no loss.
- Log: 5 exceptions with no reads, LOG_DEPTH=4 -> 4 entries kept, log_overflow=1. Full log with push+pop in the same cycle -> no overflow. sticky_clr -> flags=0, log_overflow=0.
- Reset asserted during TRAP -> trap_req=0, out_valid=0, sticky_flags=0, log_empty=1 immediately (asynchronous).
